prod24_accumulator: RTL and testbench

Streaming accumulation stage downstream of the 12x12 unsigned multiplier. It consumes 24-bit unsigned products over a valid/ready handshake, sums a programmable-length block of them, and presents one accumulated result per block on a valid/ready output. It turns the multiplier into a dot-product / MAC engine without adding combinational depth to the multiplier's output path.

---
 rtl/prod_acc_pkg.sv | 19 +
 rtl/prod24_accumulator_if.sv | 32 +++
 rtl/prod_acc_dp.sv | 53 +++++
 rtl/prod24_accumulator.sv | 97 +++++++++
 tb/tb_prod24_accumulator.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/prod_acc_pkg.sv
// Shared definitions for the product accumulator: product width, FSM states, block-length decode.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package prod_acc_pkg;

  localparam int PROD_W = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // A programmed length of zero stands for the full 2^cnt_w block.
  function automatic int unsigned len_decode(input int unsigned raw, input int unsigned cnt_w);
    return (raw == 0) ? (32'd1 << cnt_w) : raw;
  endfunction

endpackage

// File: rtl/prod24_accumulator_if.sv
// Handshake bundle between the multiplier-side producer, the accumulator and the result consumer.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the product side, out_valid/out_ready on the result side.
interface prod24_accumulator_if
  import prod_acc_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) ();

  logic [CNT_W-1:0]  cfg_len;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_ovf;

  // Producer/consumer side: drives products, config and result acceptance.
  modport master (
    output cfg_len, in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  // Accumulator side.
  modport slave (
    input  cfg_len, in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );

endinterface

// File: rtl/prod_acc_dp.sv
// Accumulate/carry datapath: loads the first product, adds later ones at ACC_W+1 bits, sticky carry flag.
// Latency: result of a load/add is visible one cycle after the enabling edge.
// Backpressure: none here; load/add are only pulsed by the controller on accepted products.
// Build option PROD_ACC_SAT_EN: clamp to all-ones on carry instead of wrapping.
module prod_acc_dp
  import prod_acc_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              add,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf
);

  logic [ACC_W:0]   sum;
  logic             carry;
  logic [ACC_W-1:0] acc_next;

  assign sum   = {1'b0, acc} + (ACC_W+1)'(prod);
  assign carry = sum[ACC_W];

  // Select the post-add value: wrapped sum, or all-ones once a carry appears.
  always_comb begin
    acc_next = sum[ACC_W-1:0];
`ifdef PROD_ACC_SAT_EN
    // Once at all-ones every non-zero add carries again, so the clamp holds for the rest of the block.
    if (carry) begin
      acc_next = '1;
    end
`else
    acc_next = sum[ACC_W-1:0];
`endif
  end

  // Accumulator and sticky overflow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      acc <= ACC_W'(prod);
      ovf <= 1'b0;
    end else if (add) begin
      acc <= acc_next;
      ovf <= ovf | carry;
    end
  end

endmodule

// File: rtl/prod24_accumulator.sv
// Block accumulator behind the 12x12 multiplier: sums cfg_len products, emits one result per block.
// Latency: out_valid is registered on the edge accepting the last product; visible the next cycle.
// Backpressure: result held in HOLD until out_ready; in_ready is low in HOLD (one bubble per block).
// Build option PROD_ACC_SAT_EN selects a saturating accumulator (see prod_acc_dp).
module prod24_accumulator
  import prod_acc_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) (
  input logic                clk,
  input logic                rst,
  prod24_accumulator_if.slave bus
);

  localparam logic [CNT_W:0] ONE = (CNT_W+1)'(1);

  state_t         state_q;
  state_t         state_d;
  logic [CNT_W:0] cnt_q;
  logic [CNT_W:0] len_q;
  logic [CNT_W:0] cfg_len_dec;
  logic           accept;
  logic           load;
  logic           add;

  assign cfg_len_dec = (CNT_W+1)'(len_decode(32'(bus.cfg_len), CNT_W));

  // in_ready comes from state only, so out_ready never reaches it combinationally.
  assign bus.in_ready  = ~rst & (state_q != HOLD);
  assign bus.out_valid = (state_q == HOLD);
  assign accept        = bus.in_valid & bus.in_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath enables.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    add     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          load    = 1'b1;
          state_d = (cfg_len_dec == ONE) ? HOLD : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          add = 1'b1;
          if ((cnt_q + ONE) == len_q) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Product counter and block length latched on the first product of a block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      len_q <= '0;
    end else if (load) begin
      cnt_q <= ONE;
      len_q <= cfg_len_dec;
    end else if (add) begin
      cnt_q <= cnt_q + ONE;
    end
  end

  prod_acc_dp #(
    .ACC_W(ACC_W)
  ) u_dp (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .add  (add),
    .prod (bus.in_prod),
    .acc  (bus.out_sum),
    .ovf  (bus.out_ovf)
  );

endmodule

// File: tb/tb_prod24_accumulator.sv
// Directed bench for prod24_accumulator: default-width instance plus a 24-bit instance for overflow.
// Expected block results come from a bench-side arithmetic model and flow through a scoreboard queue.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_prod24_accumulator;
  import prod_acc_pkg::*;

  typedef struct packed {
    logic [63:0] sum;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  logic [63:0] model_sum;

  prod24_accumulator_if #(.ACC_W(32), .CNT_W(8)) bus ();
  prod24_accumulator_if #(.ACC_W(24), .CNT_W(8)) b24 ();

  prod24_accumulator #(.ACC_W(32), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  prod24_accumulator #(.ACC_W(24), .CNT_W(8)) dut24 (
    .clk (clk),
    .rst (rst),
    .bus (b24)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model of one block result from its full-precision sum.
  function automatic exp_t model_result(input logic [63:0] raw, input int acc_w);
    exp_t        e;
    logic [63:0] lim;
    lim   = 64'd1 << acc_w;
    e.ovf = (raw >= lim);
`ifdef PROD_ACC_SAT_EN
    e.sum = e.ovf ? (lim - 64'd1) : raw;
`else
    e.sum = raw & (lim - 64'd1);
`endif
    return e;
  endfunction

  task automatic send(input logic [23:0] p);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_prod  = p;
    while (bus.in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("in_ready_wait", 64'(waited < 50), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    model_sum    = model_sum + 64'(p);
  endtask

  task automatic push_block();
    exp_q.push_back(model_result(model_sum, 32));
    model_sum = '0;
  endtask

  task automatic take_result(input int hold_cycles);
    int   waited = 0;
    exp_t e;
    while (bus.out_valid !== 1'b1 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    chk("out_valid_wait", 64'(waited < 400), 64'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk("out_sum", 64'(bus.out_sum), e.sum);
    chk("out_ovf", 64'(bus.out_ovf), 64'(e.ovf));
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_sum", 64'(bus.out_sum), e.sum);
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("valid_drop", 64'(bus.out_valid), 64'd0);
    chk("reopen_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    exp_t e24;
    model_sum     = '0;
    rst           = 1'b1;
    bus.cfg_len   = '0;
    bus.in_valid  = 1'b0;
    bus.in_prod   = '0;
    bus.out_ready = 1'b0;
    b24.cfg_len   = '0;
    b24.in_valid  = 1'b0;
    b24.in_prod   = '0;
    b24.out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_sum", 64'(bus.out_sum), 64'd0);
    chk("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Single block of 4, back-to-back, with latency check
    bus.cfg_len = 8'd4;
    send(24'd1);
    send(24'd2);
    send(24'd3);
    chk("early_out_valid", 64'(bus.out_valid), 64'd0);
    send(24'd4);
    chk("latency_out_valid", 64'(bus.out_valid), 64'd1);
    push_block();
    take_result(3);

    // Maximum length block (cfg_len 0 -> 256 products)
    bus.cfg_len = 8'd0;
    for (int i = 0; i < 256; i++) begin
      if (i == 255) chk("max_len_not_early", 64'(bus.out_valid), 64'd0);
      send(24'd16769025);
    end
    push_block();
    take_result(1);

    // Backpressure: result held while next product waits
    bus.cfg_len = 8'd3;
    send(24'd10);
    send(24'd20);
    send(24'd30);
    push_block();
    bus.cfg_len  = 8'd2;
    bus.in_valid = 1'b1;
    bus.in_prod  = 24'd100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_out_sum", 64'(bus.out_sum), 64'd60);
    end
    take_result(0);
    send(24'd100);
    send(24'd200);
    push_block();
    take_result(1);

    // Reset mid-block discards the partial sum
    bus.cfg_len = 8'd8;
    send(24'd50);
    send(24'd60);
    send(24'd70);
    model_sum = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_out_sum", 64'(bus.out_sum), 64'd0);
    chk("midrst_in_ready_back", 64'(bus.in_ready), 64'd1);
    bus.cfg_len = 8'd2;
    send(24'd5);
    send(24'd7);
    push_block();
    take_result(1);

    // Length 1
    bus.cfg_len = 8'd1;
    send(24'd9);
    chk("len1_latency", 64'(bus.out_valid), 64'd1);
    push_block();
    take_result(1);

    // Gapped input; cfg_len change mid-block is ignored
    bus.cfg_len = 8'd3;
    send(24'd1);
    bus.cfg_len = 8'd5;
    repeat (2) @(negedge clk);
    send(24'd1);
    repeat (3) @(negedge clk);
    chk("gap_no_early_valid", 64'(bus.out_valid), 64'd0);
    send(24'd1);
    push_block();
    take_result(1);

    // Overflow on the 24-bit instance
    b24.cfg_len  = 8'd2;
    b24.in_valid = 1'b1;
    b24.in_prod  = 24'd16769025;
    chk("ovf_in_ready", 64'(b24.in_ready), 64'd1);
    @(negedge clk);
    chk("ovf_in_ready2", 64'(b24.in_ready), 64'd1);
    @(negedge clk);
    b24.in_valid = 1'b0;
    e24 = model_result(64'd16769025 * 64'd2, 24);
    chk("ovf_out_valid", 64'(b24.out_valid), 64'd1);
    chk("ovf_out_sum", 64'(b24.out_sum), e24.sum);
    chk("ovf_out_ovf", 64'(b24.out_ovf), 64'(e24.ovf));
    b24.out_ready = 1'b1;
    @(negedge clk);
    b24.out_ready = 1'b0;
    chk("ovf_valid_drop", 64'(b24.out_valid), 64'd0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
